// File: rtl/add_sub_arbiter_if.sv
// add_sub_arbiter_if: request/response/datapath bundle between two clients, the arbiter and prog_add_sub.
// Signal prefixes are from the arbiter's point of view (slave modport).
interface add_sub_arbiter_if #(parameter int DATA_WD = 4);
  logic [1:0]           i_req_vld;
  logic [1:0]           o_req_rdy;
  logic [2*DATA_WD-1:0] i_req_a;
  logic [2*DATA_WD-1:0] i_req_b;
  logic [1:0]           i_req_mode;
  logic [DATA_WD-1:0]   o_dp_a;
  logic [DATA_WD-1:0]   o_dp_b;
  logic                 o_dp_mode;
  logic [DATA_WD:0]     i_dp_arith_out;
  logic                 i_dp_ovr;
  logic                 o_rsp_vld;
  logic                 i_rsp_rdy;
  logic                 o_rsp_id;
  logic [DATA_WD:0]     o_rsp_data;
  logic                 o_rsp_ovr;
  modport slave (
    input  i_req_vld, i_req_a, i_req_b, i_req_mode, i_dp_arith_out, i_dp_ovr, i_rsp_rdy,
    output o_req_rdy, o_dp_a, o_dp_b, o_dp_mode, o_rsp_vld, o_rsp_id, o_rsp_data, o_rsp_ovr
  );
  modport master (
    output i_req_vld, i_req_a, i_req_b, i_req_mode, i_dp_arith_out, i_dp_ovr, i_rsp_rdy,
    input  o_req_rdy, o_dp_a, o_dp_b, o_dp_mode, o_rsp_vld, o_rsp_id, o_rsp_data, o_rsp_ovr
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin share of one prog_add_sub datapath between two requesters.
// Optional ADD_SUB_GRANT_CNT_EN adds per-requester 8-bit accepted-request counters.
module add_sub_arbiter #(
  parameter int DATA_WD = 4,
  parameter int DP_LAT  = 1
) (
  input logic i_clk,
  input logic i_rst_n,
  add_sub_arbiter_if.slave bus
`ifdef ADD_SUB_GRANT_CNT_EN
  ,
  output logic [7:0] o_gnt_cnt0,
  output logic [7:0] o_gnt_cnt1
`endif
);
  localparam int CW = $clog2(DP_LAT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2;
  logic [1:0]         r_state;
  logic               r_ptr, r_id, r_dp_mode, r_rsp_vld, r_rsp_id, r_rsp_ovr;
  logic [CW-1:0]      r_cnt;
  logic [DATA_WD-1:0] r_dp_a, r_dp_b;
  logic [DATA_WD:0]   r_rsp_data;
  logic               w_acc, w_gnt;
  logic [1:0]         w_rdy;
  assign w_acc = (r_state == S_IDLE) && |bus.i_req_vld;
  // Contention goes to the pointer; a lone requester wins regardless of it.
  assign w_gnt = &bus.i_req_vld ? r_ptr : bus.i_req_vld[1];
  assign w_rdy = w_acc ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_req_rdy  = w_rdy;
  assign bus.o_dp_a     = r_dp_a;
  assign bus.o_dp_b     = r_dp_b;
  assign bus.o_dp_mode  = r_dp_mode;
  assign bus.o_rsp_vld  = r_rsp_vld;
  assign bus.o_rsp_id   = r_rsp_id;
  assign bus.o_rsp_data = r_rsp_data;
  assign bus.o_rsp_ovr  = r_rsp_ovr;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      r_dp_a     <= '0;
      r_dp_b     <= '0;
      r_dp_mode  <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_ovr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_dp_a    <= w_gnt ? bus.i_req_a[2*DATA_WD-1:DATA_WD] : bus.i_req_a[DATA_WD-1:0];
          r_dp_b    <= w_gnt ? bus.i_req_b[2*DATA_WD-1:DATA_WD] : bus.i_req_b[DATA_WD-1:0];
          r_dp_mode <= bus.i_req_mode[w_gnt];
          r_id      <= w_gnt;
          r_cnt     <= CW'(DP_LAT - 1);
          r_state   <= S_EXEC;
        end
        S_EXEC: if (r_cnt == '0) begin
          r_rsp_data <= bus.i_dp_arith_out;
          r_rsp_ovr  <= bus.i_dp_ovr;
          r_rsp_id   <= r_id;
          r_rsp_vld  <= 1'b1;
          r_state    <= S_RESP;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
        S_RESP: if (bus.i_rsp_rdy) begin
          r_rsp_vld <= 1'b0;
          r_ptr     <= ~r_rsp_id;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef ADD_SUB_GRANT_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt_cnt0 <= 8'd0;
      o_gnt_cnt1 <= 8'd0;
    end else begin
      o_gnt_cnt0 <= o_gnt_cnt0 + 8'(w_rdy[0]);
      o_gnt_cnt1 <= o_gnt_cnt1 + 8'(w_rdy[1]);
    end
  end
`endif
endmodule

// File: tb/tb_add_sub_arbiter.sv
// tb_add_sub_arbiter: vector table, hand sequences and random ops against a transaction-level model.
module tb_add_sub_arbiter;
  localparam int DW  = 4;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0, n_err = 0, cyc = 0, acc_cyc = 0;
  logic ptr = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  add_sub_arbiter_if #(.DATA_WD(DW)) bus ();
`ifdef ADD_SUB_GRANT_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif
  add_sub_arbiter #(.DATA_WD(DW), .DP_LAT(LAT)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
`ifdef ADD_SUB_GRANT_CNT_EN
    ,
    .o_gnt_cnt0(cnt0),
    .o_gnt_cnt1(cnt1)
`endif
  );
  // Stand-in for prog_add_sub: unsigned DATA_WD+1 result, two's-complement overflow flag.
  always_comb begin
    bus.i_dp_arith_out = bus.o_dp_mode ? {1'b0, bus.o_dp_a} - {1'b0, bus.o_dp_b}
                                       : {1'b0, bus.o_dp_a} + {1'b0, bus.o_dp_b};
    bus.i_dp_ovr = bus.o_dp_mode
      ? (bus.o_dp_a[DW-1] != bus.o_dp_b[DW-1]) && (bus.i_dp_arith_out[DW-1] != bus.o_dp_a[DW-1])
      : (bus.o_dp_a[DW-1] == bus.o_dp_b[DW-1]) && (bus.i_dp_arith_out[DW-1] != bus.o_dp_a[DW-1]);
  end
  typedef struct {
    logic [1:0] vld;
    logic [3:0] a0, b0, a1, b1;
    logic       m0, m1;
    int         stall, eg;
    logic [4:0] ed;
  } vec_t;
  vec_t tv[8];
  function automatic vec_t mk(logic [1:0] v, logic [3:0] a0, b0, logic m0, logic [3:0] a1, b1,
                              logic m1, int st, int eg, logic [4:0] ed);
    vec_t t;
    t.vld = v; t.a0 = a0; t.b0 = b0; t.m0 = m0; t.a1 = a1; t.b1 = b1; t.m1 = m1;
    t.stall = st; t.eg = eg; t.ed = ed;
    return t;
  endfunction
  function automatic void ref_op(input logic [3:0] a, b, input logic m,
                                 output logic [4:0] d, output logic o);
    int sa, sb, r, u;
    sa = $signed(a);
    sb = $signed(b);
    r  = m ? sa - sb : sa + sb;
    u  = m ? int'(a) - int'(b) : int'(a) + int'(b);
    d  = 5'(u);
    o  = (r > 7) || (r < -8);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // One complete transaction; entered and left just after a falling edge.
  task automatic op(input logic [1:0] vld, input logic [3:0] a0, b0, input logic m0,
                    input logic [3:0] a1, b1, input logic m1, input int stall, output int g);
    int k;
    logic [3:0] ga, gb;
    logic gm, eo;
    logic [4:0] ed, d0;
    bus.i_req_vld  = vld;
    bus.i_req_a    = {a1, a0};
    bus.i_req_b    = {b1, b0};
    bus.i_req_mode = {m1, m0};
    bus.i_rsp_rdy  = (stall == 0);
    g = (vld == 2'b11) ? int'(ptr) : (vld[1] ? 1 : 0);
    k = 0;
    #1;
    while (bus.o_req_rdy == 2'b00 && k < 10) begin
      @(negedge clk); #1; k++;
    end
    chk("req_rdy", bus.o_req_rdy, g ? 2 : 1);
    acc_cyc = cyc;
    ga = g ? a1 : a0;
    gb = g ? b1 : b0;
    gm = g ? m1 : m0;
    ref_op(ga, gb, gm, ed, eo);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.i_req_vld = 2'b00;
        chk("exec_rsp_vld", bus.o_rsp_vld, 0);
        chk("dp_a", bus.o_dp_a, ga);
        chk("dp_b", bus.o_dp_b, gb);
        chk("dp_mode", bus.o_dp_mode, gm);
      end
    end while (!bus.o_rsp_vld && k < 20);
    chk("latency", k, LAT + 1);
    chk("rsp_data", bus.o_rsp_data, ed);
    chk("rsp_id", bus.o_rsp_id, g);
    chk("rsp_ovr", bus.o_rsp_ovr, eo);
    d0 = bus.o_rsp_data;
    for (int s = 0; s < stall; s++) begin
      bus.i_req_vld = 2'b11;
      @(negedge clk);
      chk("stall_vld", bus.o_rsp_vld, 1);
      chk("stall_data", bus.o_rsp_data, d0);
      chk("stall_id", bus.o_rsp_id, g);
      chk("stall_req_rdy", bus.o_req_rdy, 0);
    end
    bus.i_req_vld = 2'b00;
    bus.i_rsp_rdy = 1'b1;
    @(negedge clk);
    chk("rsp_done", bus.o_rsp_vld, 0);
    ptr = ~g[0];
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 1'b0;
  endtask
  initial begin
    int g, prev;
    bus.i_req_vld = 2'b00; bus.i_req_a = '0; bus.i_req_b = '0; bus.i_req_mode = 2'b00;
    bus.i_rsp_rdy = 1'b0;
    tv[0] = mk(2'b01, 4'd3, 4'd5, 1'b0, 4'd0, 4'd0, 1'b0, 0, 0, 5'd8);
    tv[1] = mk(2'b10, 4'd0, 4'd0, 1'b0, 4'd5, 4'd3, 1'b1, 0, 1, 5'd2);
    tv[2] = mk(2'b11, 4'd1, 4'd2, 1'b0, 4'd7, 4'd1, 1'b1, 0, 0, 5'd3);
    tv[3] = mk(2'b11, 4'd1, 4'd2, 1'b0, 4'd7, 4'd1, 1'b1, 0, 1, 5'd6);
    tv[4] = mk(2'b11, 4'd15, 4'd15, 1'b0, 4'd7, 4'd1, 1'b1, 0, 0, 5'd30);
    tv[5] = mk(2'b01, 4'd0, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0, 0, 0, 5'd31);
    tv[6] = mk(2'b11, 4'd2, 4'd2, 1'b0, 4'd9, 4'd4, 1'b0, 5, 1, 5'd13);
    tv[7] = mk(2'b11, 4'd2, 4'd2, 1'b0, 4'd9, 4'd4, 1'b0, 0, 0, 5'd4);
    #2;
    chk("rst_rsp_vld", bus.o_rsp_vld, 0);
    chk("rst_rsp_id", bus.o_rsp_id, 0);
    chk("rst_rsp_data", bus.o_rsp_data, 0);
    chk("rst_rsp_ovr", bus.o_rsp_ovr, 0);
    chk("rst_dp", {bus.o_dp_mode, bus.o_dp_b, bus.o_dp_a}, 0);
    chk("rst_req_rdy", bus.o_req_rdy, 0);
    do_reset();
    // both requesters continuously valid: strict alternation, DP_LAT+2 cycles apart
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      op(2'b11, 4'd1, 4'd1, 1'b0, 4'd6, 4'd2, 1'b1, 0, g);
      chk("alt_gnt", g, i % 2);
      if (i > 0) chk("alt_gap", acc_cyc - prev, LAT + 2);
      prev = acc_cyc;
    end
    foreach (tv[i]) begin
      op(tv[i].vld, tv[i].a0, tv[i].b0, tv[i].m0, tv[i].a1, tv[i].b1, tv[i].m1, tv[i].stall, g);
      chk($sformatf("tbl%0d_gnt", i), g, tv[i].eg);
      chk($sformatf("tbl%0d_data", i), bus.o_rsp_data, tv[i].ed);
    end
    // reset while the accepted op sits in EXEC
    bus.i_req_vld = 2'b10; bus.i_req_a = 8'h50; bus.i_req_b = 8'h30; bus.i_req_mode = 2'b10;
    #1;
    chk("mid_req_rdy", bus.o_req_rdy, 2);
    @(negedge clk);
    bus.i_req_vld = 2'b00;
    chk("mid_dp_mode", bus.o_dp_mode, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", bus.o_rsp_vld, 0);
    chk("mid_rst_dp", {bus.o_dp_mode, bus.o_dp_b, bus.o_dp_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", bus.o_rsp_vld, 0);
    end
    op(2'b11, 4'd4, 4'd4, 1'b1, 4'd2, 4'd1, 1'b0, 0, g);
    chk("post_rst_gnt", g, 0);
    for (int i = 0; i < 60; i++)
      op(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 1'($urandom),
         4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)), g);
`ifdef ADD_SUB_GRANT_CNT_EN
    do_reset();
    chk("cnt_rst", {cnt1, cnt0}, 0);
    for (int i = 0; i < 256; i++) begin
      op(2'b01, 4'(i), 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 0, g);
      if (i == 0) chk("cnt0_one", cnt0, 1);
    end
    chk("cnt0_wrap", cnt0, 0);
    chk("cnt1_idle", cnt1, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
